freq_meter: RTL and testbench

- Measures a slow or divided clock (SigIn), typically the output of the team's programmable frequency divider, against the system clock Clk.
- Reports the period and the high time of SigIn in Clk cycles, with a one-cycle Valid strobe per completed measurement.
- Sits on the read-back/self-test side of the divider, so software can check the configured division ratio and duty cycle.

---
 rtl/freq_meter.sv | 180 ++++++++++++++++++
 tb/tb_freq_meter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// Measures period and high time of sig_in_i in clk_i cycles, with a one-cycle valid strobe.
// Define FREQ_METER_AVG_EN to report the mean of four periods per valid strobe.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | disabled; counters held at zero
// S_ARM     | waiting for the first rising edge, timeout timer running
// S_MEASURE | counting between rising edges, result on every edge
module freq_meter #(
   parameter int unsigned      WIDTH   = 32,
   parameter logic [WIDTH-1:0] TIMEOUT = WIDTH'(32'hFFFF_FFFF)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             enable_i,
   input  logic             sig_in_i,
   output logic [WIDTH-1:0] period_o,
   output logic [WIDTH-1:0] high_time_o,
   output logic             valid_o,
   output logic             timeout_o
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARM     = 2'd1,
      S_MEASURE = 2'd2
   } state_e;

   localparam logic [WIDTH-1:0] CNT_LAST = TIMEOUT - WIDTH'(1);

   state_e           state_q, state_d;
   logic [2:0]       sync_q;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] high_cnt_q, high_cnt_d;
   logic [WIDTH-1:0] period_q, period_d;
   logic [WIDTH-1:0] high_time_q, high_time_d;
   logic             valid_q, valid_d;
   logic             timeout_q, timeout_d;

   logic             sig_s;
   logic             rise;
   logic             cnt_last;
   logic             meas_done;
   logic             report;
   logic [WIDTH-1:0] result_period;

   assign sig_s     = sync_q[1];
   assign rise      = sync_q[1] & ~sync_q[2];
   assign cnt_last  = (cnt_q == CNT_LAST);
   assign meas_done = enable_i && (state_q == S_MEASURE) && rise;

`ifdef FREQ_METER_AVG_EN
   logic [WIDTH+1:0] acc_q, acc_d;
   logic [1:0]       idx_q, idx_d;
   logic [WIDTH+1:0] acc_sum;
   logic             to_hit;

   assign acc_sum       = acc_q + {2'b00, cnt_q};
   assign result_period = acc_sum[WIDTH+1:2];
   assign to_hit        = enable_i && (state_q != S_IDLE) && !rise && cnt_last;

   always_comb begin
      acc_d  = acc_q;
      idx_d  = idx_q;
      report = 1'b0;
      if (!enable_i || to_hit) begin
         acc_d = '0;
         idx_d = '0;
      end else if (meas_done) begin
         if (idx_q == 2'd3) begin
            report = 1'b1;
            acc_d  = '0;
            idx_d  = '0;
         end else begin
            acc_d = acc_sum;
            idx_d = idx_q + 2'd1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc_q <= '0;
         idx_q <= '0;
      end else begin
         acc_q <= acc_d;
         idx_q <= idx_d;
      end
   end
`else
   assign report        = meas_done;
   assign result_period = cnt_q;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         sync_q      <= '0;
         cnt_q       <= '0;
         high_cnt_q  <= '0;
         period_q    <= '0;
         high_time_q <= '0;
         valid_q     <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync_q      <= {sync_q[1:0], sig_in_i};
         cnt_q       <= cnt_d;
         high_cnt_q  <= high_cnt_d;
         period_q    <= period_d;
         high_time_q <= high_time_d;
         valid_q     <= valid_d;
         timeout_q   <= timeout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!enable_i) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:    state_d = S_ARM;
            S_ARM:     if (rise) state_d = S_MEASURE;
            S_MEASURE: if (!rise && cnt_last) state_d = S_ARM;
            default:   state_d = S_IDLE;
         endcase
      end
   end

   // A rise always beats a timeout landing on the same cycle.
   always_comb begin
      cnt_d       = cnt_q;
      high_cnt_d  = high_cnt_q;
      period_d    = period_q;
      high_time_d = high_time_q;
      valid_d     = 1'b0;
      timeout_d   = timeout_q;
      if (!enable_i) begin
         cnt_d      = '0;
         high_cnt_d = '0;
      end else begin
         case (state_q)
            S_ARM, S_MEASURE: begin
               if (rise) begin
                  cnt_d      = WIDTH'(1);
                  high_cnt_d = WIDTH'(1);
                  if (state_q == S_MEASURE) begin
                     timeout_d = 1'b0;
                     if (report) begin
                        period_d    = result_period;
                        high_time_d = high_cnt_q;
                        valid_d     = 1'b1;
                     end
                  end
               end else if (cnt_last) begin
                  timeout_d  = 1'b1;
                  cnt_d      = '0;
                  high_cnt_d = '0;
               end else begin
                  cnt_d = cnt_q + WIDTH'(1);
                  if (state_q == S_MEASURE) begin
                     high_cnt_d = high_cnt_q + WIDTH'(sig_s);
                  end
               end
            end
            default: begin
               cnt_d      = '0;
               high_cnt_d = '0;
            end
         endcase
      end
   end

   assign period_o    = period_q;
   assign high_time_o = high_time_q;
   assign valid_o     = valid_q;
   assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter: constant vector table, randomized waveforms against a
// sample-history reference model, and hand sequences for timeout, enable gaps and async reset.
module tb_freq_meter;
   localparam int W    = 32;
   localparam int TO   = 100;
   localparam int MAXC = 1024;

   logic         clk;
   logic         rst;
   logic         en;
   logic         sig;
   logic [W-1:0] period;
   logic [W-1:0] high_time;
   logic         valid;
   logic         timeout;

   freq_meter #(.WIDTH(W), .TIMEOUT(W'(TO))) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .enable_i   (en),
      .sig_in_i   (sig),
      .period_o   (period),
      .high_time_o(high_time),
      .valid_o    (valid),
      .timeout_o  (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int hi;
      int lo;
      int n_per;
      int exp_p;
      int exp_h;
   } vec_t;

   vec_t vecs[6];
   logic hist[0:MAXC-1];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc;
   int   nv;
   int   last_v;
   int   first_v;
   int   prev_k;
   int   exp_per;
   int   exp_hi;
   int   t_edge;
   int   got_p;
   int   got_h;
   int   got_t;
   int   hi;
   int   lo;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      en  = 1'b0;
      sig = 1'b0;
      cyc = 0;
      repeat (2) @(negedge clk);
      en  = 1'b1;
      rst = 1'b0;
   endtask

   // One clock: sig is sampled at edge number cyc, outputs are read 1 ns after it.
   task automatic tick(input logic s);
      if (cyc < MAXC) hist[cyc] = s;
      sig = s;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // A 0->1 step in the sampled input at sample k is acted on at edge k+2.
   function automatic bit rise_edge(input int e);
      logic a, b;
      if (e < 2) return 1'b0;
      a = hist[e-2];
      b = (e >= 3) ? hist[e-3] : 1'b0;
      return (a === 1'b1) && (b === 1'b0);
   endfunction

   task automatic model_check();
      int  e, k;
      bit  ev;
      e  = cyc - 1;
      ev = 1'b0;
      if (rise_edge(e)) begin
         k = e - 2;
         if (prev_k >= 0) begin
            ev      = 1'b1;
            exp_per = k - prev_k;
            exp_hi  = 0;
            for (int i = prev_k; i < k; i++) exp_hi += int'(hist[i]);
         end
         prev_k = k;
      end
      check("rnd_valid", valid, ev);
      check("rnd_period", period, exp_per);
      check("rnd_high", high_time, exp_hi);
   endtask

   task automatic tbl_check(input int v);
      int e;
      if (valid === 1'b1) begin
         e = cyc - 1;
         check("tbl_period", period, vecs[v].exp_p);
         check("tbl_high", high_time, vecs[v].exp_h);
         check("tbl_timeout", timeout, 0);
         if (last_v < 0) check("tbl_first_valid", e, 2 + vecs[v].exp_p);
         else            check("tbl_valid_gap", e - last_v, vecs[v].exp_p);
         last_v = e;
         nv++;
      end
   endtask

   task automatic grab_first();
      if (valid === 1'b1) begin
         if (nv == 0) begin
            got_p = period;
            got_h = high_time;
            got_t = timeout;
            first_v = cyc - 1;
         end
         nv++;
      end
   endtask

   initial begin
      rst = 1'b1;
      en  = 1'b0;
      sig = 1'b0;
      cyc = 0;

      reset_dut();
      check("rst_period", period, 0);
      check("rst_high", high_time, 0);
      check("rst_valid", valid, 0);
      check("rst_timeout", timeout, 0);

`ifdef FREQ_METER_AVG_EN
      // Periods 8,8,10,10 from rises at samples 0,8,16,26,36; the 5th rise lands at edge 38.
      nv = 0; first_v = -1; got_p = 0; got_h = 0; got_t = 0;
      for (int p = 0; p < 5; p++) begin
         hi = (p < 2) ? 4 : ((p < 4) ? 5 : 1);
         lo = (p < 2) ? 4 : 5;
         repeat (hi) begin tick(1'b1); grab_first(); end
         repeat (lo) begin tick(1'b0); grab_first(); end
      end
      check("avg_valid_count", nv, 1);
      check("avg_valid_edge", first_v, 38);
      check("avg_period", got_p, 9);
      check("avg_high", got_h, 5);
`else
      // Async reset between edges, right after a valid strobe.
      for (int e = 0; e < 19; e++) tick(((e % 8) < 4) ? 1'b1 : 1'b0);
      check("ar_pre_valid", valid, 1);
      check("ar_pre_period", period, 8);
      check("ar_pre_high", high_time, 4);
      #2;
      rst = 1'b1;
      #1;
      check("ar_period", period, 0);
      check("ar_high", high_time, 0);
      check("ar_valid", valid, 0);
      check("ar_timeout", timeout, 0);

      // Constant vectors; the 5/94 row puts a rise on the cycle the timeout would fire.
      vecs[0] = '{4, 4, 6, 8, 4};
      vecs[1] = '{3, 7, 5, 10, 3};
      vecs[2] = '{1, 1, 10, 2, 1};
      vecs[3] = '{2, 5, 5, 7, 2};
      vecs[4] = '{7, 1, 5, 8, 7};
      vecs[5] = '{5, 94, 3, 99, 5};
      for (int v = 0; v < 6; v++) begin
         reset_dut();
         nv = 0;
         last_v = -1;
         for (int p = 0; p < vecs[v].n_per; p++) begin
            repeat (vecs[v].hi) begin tick(1'b1); tbl_check(v); end
            repeat (vecs[v].lo) begin tick(1'b0); tbl_check(v); end
         end
         repeat (3) begin tick(1'b0); tbl_check(v); end
         check("tbl_valid_count", nv, vecs[v].n_per - 1);
      end

      // Random high/low lengths against the sample-history model.
      reset_dut();
      prev_k = -1; exp_per = 0; exp_hi = 0;
      while (cyc < 600) begin
         hi = $urandom_range(9, 1);
         lo = $urandom_range(9, 1);
         repeat (hi) begin tick(1'b1); model_check(); end
         repeat (lo) begin tick(1'b0); model_check(); end
      end
      check("rnd_timeout", timeout, 0);

      // Timeout: last rise acted on at edge 18, Timeout must first appear at edge 18+TO-1.
      reset_dut();
      repeat (3) begin
         repeat (4) tick(1'b1);
         repeat (4) tick(1'b0);
      end
      t_edge = -1;
      for (int i = 0; i < 200 && t_edge < 0; i++) begin
         tick(1'b0);
         if (timeout === 1'b1) t_edge = cyc - 1;
      end
      check("to_edge", t_edge, 18 + TO - 1);
      check("to_period_hold", period, 8);
      check("to_high_hold", high_time, 4);
      repeat (5) tick(1'b0);
      nv = 0; got_p = 0; got_h = 0; got_t = 1; first_v = -1;
      for (int p = 0; p < 4; p++) begin
         repeat (4) begin tick(1'b1); grab_first(); end
         repeat (4) begin tick(1'b0); grab_first(); end
      end
      check("to_restart_valids", nv, 3);
      check("to_restart_period", got_p, 8);
      check("to_restart_high", got_h, 4);
      check("to_restart_timeout", got_t, 0);

      // Enable low over edges 22..41 and again from 66 (a rise edge); rises sit at 2+8j.
      // Re-armed at 42 (rise ignored in IDLE), first rise at 50, first valid at 58.
      reset_dut();
      nv = 0; first_v = -1;
      for (int e = 0; e < 71; e++) begin
         en = (e < 22 || (e >= 42 && e < 66)) ? 1'b1 : 1'b0;
         tick(((e % 8) < 4) ? 1'b1 : 1'b0);
         if ((e >= 22 && e < 42) || e >= 66) check("en_gap_valid", valid, 0);
         if (e >= 42 && valid === 1'b1) begin
            nv++;
            if (first_v < 0) begin
               first_v = e;
               check("en_period", period, 8);
               check("en_high", high_time, 4);
            end
         end
      end
      check("en_first_valid", first_v, 58);
      check("en_valid_count", nv, 1);
      check("en_period_hold", period, 8);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
